reg_file: RTL
=============

Name: reg_file

Overview:
- 8 x 8-bit general-purpose register file. Sits directly upstream of the ALU; writeback target of the ALU result.
- Two asynchronous read ports, OUT1 and OUT2, drive the ALU operand inputs: OUT1 goes to DATA1, and OUT2 goes to DATA2 through the immediate/negation muxes.
- One synchronous write port accepts the ALU RESULT, or memory read data, at the rising clock edge.

Parameters:
- NREGS, 8, number of registers. Must be a power of two.
- WIDTH, 8, register width in bits.
- AW, 3, address width; equals log2(NREGS).
- RD_DLY, 2, read-path propagation delay in ns. Simulation-only; 0 disables it.
- WR_DLY, 1, clock-to-update delay in ns. Simulation-only; 0 disables it.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- WRITE  input  1  write enable from the control unit.
- BUSYWAIT  input  1  memory stall; when high, writes are suppressed.
- INADDRESS  input  AW  write register index.
- IN  input  WIDTH  write data (ALU RESULT or memory read data).
- OUT1ADDRESS  input  AW  read port 1 index.
- OUT2ADDRESS  input  AW  read port 2 index.
- OUT1  output  WIDTH  contents of register OUT1ADDRESS.
- OUT2  output  WIDTH  contents of register OUT2ADDRESS.

Behaviour:
- Storage: NREGS x WIDTH flops; no other state.
- Reset: at a rising CLK edge with RESET=1, all registers become 0 after WR_DLY.
  - RESET has priority over WRITE.
  - A write presented in a reset cycle is discarded.
  - RESET has no effect between edges.
- OUT1/OUT2 reset value: 0, valid RD_DLY after the reset edge, because the outputs track register contents.
- Write: at a rising CLK edge with RESET=0, WRITE=1, BUSYWAIT=0, reg[INADDRESS] <= IN after WR_DLY.
- Write latency is 1 edge. No write occurs on the falling edge or between edges.
- BUSYWAIT=1 at the edge: no write; the register keeps its old value. The control unit holds WRITE/IN/INADDRESS until BUSYWAIT falls, and the write lands on the first edge with BUSYWAIT=0.
- Read: combinational, OUTn = reg[OUTnADDRESS] after RD_DLY.
  - Re-evaluates on any change of the address or of the addressed register.
  - No bypass: reading the register being written returns the old value until the edge, then the new value RD_DLY after the update.
- Both read ports may address the same register, and either may equal INADDRESS. Both ports are then independent and identical.
- Register 0 is an ordinary writable register; it is not hardwired to zero.
- X/Z on WRITE at an edge: the simulation model must not corrupt the array. Treat it as no write and issue a $display warning.
- No address range check is needed: AW exactly covers NREGS.
- Reset mid-stall (RESET=1, BUSYWAIT=1): reset still clears the array.

Decomposition:
- Shared include file holds REG_W, REG_AW, NREGS and the default delay constants. The ALU and CPU top use the same file.
- Single flat module; array as reg [WIDTH-1:0] regs [0:NREGS-1].
- No sub-module is natural.

Test Plan:
- Reset clear: preload r3=0x5A; RESET=1 for one edge -> OUT1(addr 3)=0x00 and OUT2(addr 7)=0x00 within RD_DLY after the edge; all 8 registers read 0.
- Basic write/read: WRITE=1, INADDRESS=2, IN=0xA5, edge -> OUT1ADDRESS=2 reads 0xA5 WR_DLY+RD_DLY after the edge; before the edge it reads the old value 0x00.
- Dual port, same register: write r5=0x3C; OUT1ADDRESS=OUT2ADDRESS=5 -> both 0x3C. Then write r5=0xFF -> both change together to 0xFF.
- Stall: WRITE=1, INADDRESS=4, IN=0x11, BUSYWAIT=1 for 3 edges -> r4 stays 0x00. BUSYWAIT drops before the 4th edge -> r4=0x11 after that edge.
- Reset priority: RESET=1 and WRITE=1 with IN=0x77, INADDRESS=1 at the same edge -> r1=0x00.
- ALU loop: r1=0x05, r2=0x03; ALU ADD writes back to r6 -> r6=0x08. An AND of r1,r2 written to r7 -> 0x01, ZERO=0. A wrap 0xFF+0x01 written to r0 -> 0x00, ALU ZERO=1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file, ALU and CPU top.
// Holds the register geometry and the default simulation delay figures.
// No logic lives here; importing it adds no hardware.
package reg_file_pkg;

    localparam int REG_W      = 8;  // register width in bits
    localparam int REG_AW     = 3;  // register index width
    localparam int NREGS      = 8;  // register count, 1 << REG_AW

    // Nominal propagation figures in ns. The synthesizable model is
    // zero-delay; these are carried for timing-annotated simulation.
    localparam int DEF_RD_DLY = 2;
    localparam int DEF_WR_DLY = 1;

    // True when n is a non-zero power of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 8 x 8 general-purpose register file: 2 async read ports, 1 sync write port.
// Latency: write lands on the next rising CLK edge; reads are combinational.
// Backpressure: BUSYWAIT=1 suppresses the write; the caller holds the request.
//
// Ports:
//   CLK, RESET              clock, synchronous active-high reset (clears all)
//   WRITE, BUSYWAIT         write enable, memory stall (stall blocks write)
//   INADDRESS, IN           write index and data
//   OUT1ADDRESS, OUT1       read port 1 index and data (ALU DATA1)
//   OUT2ADDRESS, OUT2       read port 2 index and data (ALU DATA2 path)
module reg_file
    import reg_file_pkg::*;
#(
    parameter int NREGS_P = NREGS,
    parameter int WIDTH   = REG_W,
    parameter int AW      = REG_AW,
    parameter int RD_DLY  = DEF_RD_DLY,
    parameter int WR_DLY  = DEF_WR_DLY
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WRITE,
    input  logic             BUSYWAIT,
    input  logic [AW-1:0]    INADDRESS,
    input  logic [WIDTH-1:0] IN,
    input  logic [AW-1:0]    OUT1ADDRESS,
    input  logic [AW-1:0]    OUT2ADDRESS,
    output logic [WIDTH-1:0] OUT1,
    output logic [WIDTH-1:0] OUT2
);

    // The index must cover the array exactly, since there is no range check.
    if (!is_pow2(NREGS_P) || NREGS_P != (1 << AW) || RD_DLY < 0 || WR_DLY < 0)
    begin : g_param_chk
        $error("reg_file: NREGS_P must equal 2**AW and delays must be >= 0");
    end

    logic [WIDTH-1:0] regs [0:NREGS_P-1];

    // Reset outranks the write, and a stall outranks the write even when
    // the stall and reset coincide, so reset always clears the array.
    // An unknown WRITE takes the else path, so the array is never corrupted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS_P; i++) begin
                regs[i] <= '0;
            end
        end else if (WRITE && !BUSYWAIT) begin
            regs[INADDRESS] <= IN;
        end
    end

    // No write-to-read bypass: a read of the register being written shows
    // the old contents until the edge.
    assign OUT1 = regs[OUT1ADDRESS];
    assign OUT2 = regs[OUT2ADDRESS];

    wr_known: assert property (@(posedge CLK) disable iff (RESET) !$isunknown(WRITE))
        else $warning("reg_file: WRITE is X/Z at a clock edge; write ignored");

endmodule
